// File: rtl/dec_ascii_tx_pkg.sv
// Shared definitions for the calculator output path.
//   state_e  : sequencing states of the decimal transmitter
//   CH_ZERO  : ASCII '0', base for digit characters
//   CH_LF    : ASCII line feed, default terminator
//   DIGITS_DEF : default BCD digit count (enough for a 32-bit value)
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SKIP,
        ST_EMIT,
        ST_TERM
    } state_e;

    localparam logic [7:0] CH_ZERO    = 8'h30;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam int         DIGITS_DEF = 10;

endpackage

// File: rtl/dec_ascii_tx_if.sv
// Valid/ready byte stream carrying ASCII characters.
//   char       : character byte
//   char_valid : source presents char
//   char_ready : sink accepts char this cycle
// master = character source, slave = character sink.
interface dec_ascii_tx_if;

    logic [7:0] char;
    logic       char_valid;
    logic       char_ready;

    modport master (output char, output char_valid, input char_ready);
    modport slave  (input char, input char_valid, output char_ready);

endinterface

// File: rtl/dec_ascii_tx_bcd_dd_step.sv
// One combinational double-dabble iteration.
//   bcd_i : packed BCD digits before the step
//   msb_i : next binary bit shifted into the BCD LSB
//   bcd_o : digits after the add-3 adjust and left shift
module bcd_dd_step
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic                msb_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic [4*DIGITS-1:0] adj;
    logic                unused_adj_msb;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top is always zero when DIGITS is sized
    // for the input width.
    assign unused_adj_msb = adj[4*DIGITS-1];
    assign bcd_o          = {adj[4*DIGITS-2:0], msb_i};

endmodule

// File: rtl/dec_ascii_tx.sv
// Decimal ASCII transmitter: captures an unsigned binary value, converts it
// to BCD one bit per cycle, then streams the digits MSD first with leading
// zeros suppressed, followed by a terminator byte.
//   clk, clr : clock and asynchronous active-high reset
//   load     : start a conversion of value (only while not busy)
//   value    : unsigned binary value to print
//   busy     : conversion or stream in progress
//   done     : one-cycle pulse after the terminator is accepted
//   tx       : character stream (source side)
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for load
// ST_CONVERT | one double-dabble step per cycle, WIDTH cycles
// ST_SKIP    | dropping leading zero digits
// ST_EMIT    | presenting digit characters
// ST_TERM    | presenting the terminator
module dec_ascii_tx
    import calc_pkg::*;
#(
    parameter int         WIDTH  = 32,
    parameter int         DIGITS = DIGITS_DEF,
    parameter logic [7:0] TERM   = CH_LF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    dec_ascii_tx_if.master   tx
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(DIGITS + 1);

    state_e          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   dig_cnt_q, dig_cnt_d;
    logic            done_q, done_d;

    logic [BW-1:0]   bcd_step;
    logic [3:0]      top_nib;
    logic [BW-1:0]   bcd_shl4;

    bcd_dd_step #(.DIGITS(DIGITS)) u_step (
        .bcd_i (bcd_q),
        .msb_i (bin_q[WIDTH-1]),
        .bcd_o (bcd_step)
    );

    assign top_nib  = bcd_q[BW-1 -: 4];
    assign bcd_shl4 = {bcd_q[BW-5:0], 4'h0};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            dig_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            dig_cnt_q <= dig_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        dig_cnt_d = dig_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    bit_cnt_d = CW'(WIDTH);
                    state_d   = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d     = bcd_step;
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == CW'(1)) begin
                    dig_cnt_d = DW'(DIGITS);
                    state_d   = ST_SKIP;
                end
            end
            ST_SKIP: begin
                // Keep at least one digit so that zero prints as "0".
                if (top_nib == 4'h0 && dig_cnt_q > DW'(1)) begin
                    bcd_d     = bcd_shl4;
                    dig_cnt_d = dig_cnt_q - 1'b1;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (tx.char_ready) begin
                    bcd_d     = bcd_shl4;
                    dig_cnt_d = dig_cnt_q - 1'b1;
                    if (dig_cnt_q == DW'(1)) begin
                        state_d = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                if (tx.char_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode directly from registered state so clr clears them
    // without waiting for a clock edge.
    always_comb begin
        tx.char       = 8'h00;
        tx.char_valid = 1'b0;
        if (state_q == ST_EMIT) begin
            tx.char       = CH_ZERO + {4'h0, top_nib};
            tx.char_valid = 1'b1;
        end else if (state_q == ST_TERM) begin
            tx.char       = TERM;
            tx.char_valid = 1'b1;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule
